// File: rtl/breathe_ramp_pkg.sv
// Shared definitions for the breathing duty ramp: FSM state codes and default width.
package breathe_defs;
    localparam int DEF_DUTY_W = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RISE    = 3'd1;
    localparam logic [2:0] ST_HOLD_HI = 3'd2;
    localparam logic [2:0] ST_FALL    = 3'd3;
    localparam logic [2:0] ST_HOLD_LO = 3'd4;
endpackage

// File: rtl/breathe_ramp_if.sv
// Link between the PWM output stage and the breathe ramp: wrap strobe and limits in, duty load out.
interface breathe_ramp_if import breathe_defs::*; #(
    parameter int DUTY_W = DEF_DUTY_W
) ();
    logic              enable;
    logic              period_start;
    logic [DUTY_W-1:0] min_duty;
    logic [DUTY_W-1:0] max_duty;
    logic [DUTY_W-1:0] duty;
    logic              duty_valid;
    logic              busy;

    modport master (
        output enable, period_start, min_duty, max_duty,
        input  duty, duty_valid, busy
    );
    modport slave (
        input  enable, period_start, min_duty, max_duty,
        output duty, duty_valid, busy
    );
endinterface

// File: rtl/breathe_ramp_strobe_divider.sv
// Counts strobes and fires tick_out together with every DIV-th one; clear wins over counting.
module strobe_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic strobe_in,
    output logic tick_out
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_out = strobe_in && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)          cnt_d = '0;
        else if (strobe_in) cnt_d = tick_out ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/breathe_ramp.sv
// Triangular breathing duty generator; updates only on accepted PWM wrap strobes so the
// compare value is always loaded at a period boundary.
module breathe_ramp import breathe_defs::*; #(
    parameter int DUTY_W           = DEF_DUTY_W,
    parameter int STEP             = 1,
    parameter int PERIODS_PER_STEP = 4,
    parameter int HOLD_PERIODS     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    breathe_ramp_if.slave bus
);
    localparam logic [DUTY_W:0] STEP_X = (DUTY_W + 1)'(STEP);

    logic [2:0]        state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d, lo_q, lo_d, hi_q, hi_d;
    logic              valid_q;
    logic              accept, quit, cnt_clr, step_tick, hold_tick;
    logic [DUTY_W:0]   sum, diff;
    logic              rise_sat, fall_sat;
    logic [DUTY_W-1:0] new_lo, new_hi;

    assign accept  = bus.period_start && ((state_q != ST_IDLE) || bus.enable);
    assign quit    = accept && (state_q != ST_IDLE) && !bus.enable;
    assign cnt_clr = accept && ((state_q == ST_IDLE) || !bus.enable);

    strobe_divider #(.DIV(PERIODS_PER_STEP)) u_step_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clr),
        .strobe_in(accept && ((state_q == ST_RISE) || (state_q == ST_FALL))),
        .tick_out (step_tick)
    );

    strobe_divider #(.DIV(HOLD_PERIODS)) u_hold_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clr),
        .strobe_in(accept && ((state_q == ST_HOLD_HI) || (state_q == ST_HOLD_LO))),
        .tick_out (hold_tick)
    );

    // One extra bit keeps the rise from wrapping and exposes the fall's borrow.
    assign sum      = {1'b0, duty_q} + STEP_X;
    assign diff     = {1'b0, duty_q} - STEP_X;
    assign rise_sat = sum >= {1'b0, hi_q};
    assign fall_sat = diff[DUTY_W] || (diff[DUTY_W-1:0] <= lo_q);

    assign new_lo = bus.min_duty;
    assign new_hi = (bus.max_duty > bus.min_duty) ? bus.max_duty : bus.min_duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (quit) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            case (state_q)
                ST_IDLE:    state_d = ST_RISE;
                ST_RISE:    if (step_tick && rise_sat) state_d = ST_HOLD_HI;
                ST_HOLD_HI: if (hold_tick)             state_d = ST_FALL;
                ST_FALL:    if (step_tick && fall_sat) state_d = ST_HOLD_LO;
                ST_HOLD_LO: if (hold_tick)             state_d = ST_RISE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        duty_d = duty_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        if (quit) begin
            duty_d = '0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    lo_d   = new_lo;
                    hi_d   = new_hi;
                    duty_d = new_lo;
                end
                ST_RISE: if (step_tick) duty_d = rise_sat ? hi_q : sum[DUTY_W-1:0];
                ST_FALL: if (step_tick) duty_d = fall_sat ? lo_q : diff[DUTY_W-1:0];
                ST_HOLD_LO: if (hold_tick) begin
                    lo_d = new_lo;
                    hi_d = new_hi;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q  <= '0;
            valid_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            duty_q  <= duty_d;
            valid_q <= accept;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign bus.duty       = duty_q;
    assign bus.duty_valid = valid_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule
